// File: rtl/noc_master_arbiter.sv
// noc_master_arbiter: round-robin grant stage between four processing units
// and the router fabric. One source is granted at a time and keeps the grant
// until its tlast flit. Flits are forwarded registered, tagged with the
// granted source and the destination latched at grant time.
// Optional feature: define ARB_TIMEOUT_EN to build a saturating beat counter
// that force-releases any burst reaching MAX_BURST beats without tlast.
// When the macro is not defined, bursts are unbounded and timeout_err is 0.
module noc_master_arbiter #(
  parameter int N_PROC    = 4,
  parameter int FLIT_W    = 9,
  parameter int MAX_BURST = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_PROC-1:0]        request_transfer,
  input  logic [2*N_PROC-1:0]      which_processor,
  input  logic [FLIT_W*N_PROC-1:0] data_from_proc,
  input  logic [N_PROC-1:0]        dst_busy,
  output logic [N_PROC-1:0]        master_response,
  output logic [1:0]               grant_src,
  output logic [1:0]               grant_dst,
  output logic [FLIT_W-1:0]        data_out,
  output logic                     data_out_valid,
  output logic                     timeout_err
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        rr_ptr;
  logic [1:0]        rr_next;
  logic [N_PROC-1:0] eligible;
  logic              win;
  logic [1:0]        win_idx;
  logic [FLIT_W-1:0] cur_flit;
  logic [FLIT_W-1:0] fwd_flit;
  logic              release_burst;
  logic              force_release;

  logic [N_PROC-1:0] master_response_d;
  logic [1:0]        grant_src_d;
  logic [1:0]        grant_dst_d;
  logic [FLIT_W-1:0] data_out_d;
  logic              data_out_valid_d;

  // Flit currently presented by the granted source
  assign cur_flit = data_from_proc[FLIT_W*grant_src +: FLIT_W];

  // A forced release looks exactly like a tlast flit downstream
  assign fwd_flit      = {cur_flit[FLIT_W-1] | force_release, cur_flit[FLIT_W-2:0]};
  assign release_burst = fwd_flit[FLIT_W-1];

  // A source may compete only if its destination can take a new burst
  always_comb begin
    for (int i = 0; i < N_PROC; i++) begin
      eligible[i] = request_transfer[i] & ~dst_busy[which_processor[2*i +: 2]];
    end
  end

  // Pick the first eligible source starting from the round-robin pointer
  always_comb begin
    win     = 1'b0;
    win_idx = rr_ptr;
    for (int k = 0; k < N_PROC; k++) begin
      if (!win && eligible[rr_ptr + 2'(k)]) begin
        win     = 1'b1;
        win_idx = rr_ptr + 2'(k);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] beat_cnt;

  // Count beats of the current burst; saturates instead of wrapping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      beat_cnt <= '0;
    end else if (beat_cnt != 8'hFF) begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  assign force_release = (state == XFER) && (beat_cnt == 8'(MAX_BURST - 1)) && !cur_flit[FLIT_W-1];

  // Flag the forced release for the one cycle its last beat is on data_out
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= force_release;
    end
  end
`else
  assign force_release = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  // State and round-robin pointer registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rr_ptr <= 2'd0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_next;
    end
  end

  // Grant on any eligible request; leave only on tlast or forced release
  always_comb begin
    state_next = state;
    rr_next    = rr_ptr;
    case (state)
      IDLE: begin
        if (win) begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (release_burst) begin
          state_next = IDLE;
          rr_next    = grant_src + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything is zero while idle
  always_comb begin
    master_response_d = '0;
    grant_src_d       = 2'd0;
    grant_dst_d       = 2'd0;
    data_out_d        = '0;
    data_out_valid_d  = 1'b0;
    case (state)
      IDLE: begin
        if (win) begin
          master_response_d[win_idx] = 1'b1;
          grant_src_d                = win_idx;
          grant_dst_d                = which_processor[2*win_idx +: 2];
        end
      end
      XFER: begin
        master_response_d = master_response;
        grant_src_d       = grant_src;
        grant_dst_d       = grant_dst;
        data_out_d        = fwd_flit;
        data_out_valid_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      master_response <= '0;
      grant_src       <= 2'd0;
      grant_dst       <= 2'd0;
      data_out        <= '0;
      data_out_valid  <= 1'b0;
    end else begin
      master_response <= master_response_d;
      grant_src       <= grant_src_d;
      grant_dst       <= grant_dst_d;
      data_out        <= data_out_d;
      data_out_valid  <= data_out_valid_d;
    end
  end

endmodule

// File: tb/tb_noc_master_arbiter.sv
// tb_noc_master_arbiter: directed scenarios plus randomized traffic for
// noc_master_arbiter. Processor agents drive bursts; a burst-level reference
// model predicts grants and beats into a queue that a monitor drains.
module tb_noc_master_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int MB    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int MB    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [3:0]  request_transfer;
  logic [7:0]  which_processor;
  logic [35:0] data_from_proc;
  logic [3:0]  dst_busy;
  logic [3:0]  master_response;
  logic [1:0]  grant_src;
  logic [1:0]  grant_dst;
  logic [8:0]  data_out;
  logic        data_out_valid;
  logic        timeout_err;

  noc_master_arbiter #(.MAX_BURST(MB)) dut (
      .clock            (clock),
      .reset            (reset),
      .request_transfer (request_transfer),
      .which_processor  (which_processor),
      .data_from_proc   (data_from_proc),
      .dst_busy         (dst_busy),
      .master_response  (master_response),
      .grant_src        (grant_src),
      .grant_dst        (grant_dst),
      .data_out         (data_out),
      .data_out_valid   (data_out_valid),
      .timeout_err      (timeout_err)
    );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit         beat;
    logic [1:0] src;
    logic [1:0] dst;
    logic [8:0] flit;
    bit         tout;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   beat_count;
  int   to_count;
  int   checks;
  int   errors;

  logic [8:0] flits [4][16];
  int         idx [4];
  bit         active [4];
  bit         drop1 [4];
  bit         auto_restart;
  bit         rand_mode;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: one burst in flight, winner is the first eligible
  // source counting up from the one after the last served source
  int         m_next;
  bit         m_busy;
  logic [1:0] m_src;
  logic [1:0] m_dst;
  int         m_beats;

  always @(posedge clock or negedge reset) begin : refModel
    exp_t e;
    if (!reset) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_next = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        int s;
        s = (m_next + k) % 4;
        if (!m_busy && request_transfer[s] && !dst_busy[which_processor[2*s +: 2]]) begin
          m_busy  = 1'b1;
          m_src   = 2'(s);
          m_dst   = which_processor[2*s +: 2];
          m_beats = 0;
          e.beat  = 1'b0;
          e.src   = m_src;
          e.dst   = m_dst;
          e.flit  = '0;
          e.tout  = 1'b0;
          exp_q.push_back(e);
        end
      end
    end else begin
      m_beats++;
      e.beat = 1'b1;
      e.src  = m_src;
      e.dst  = m_dst;
      e.flit = data_from_proc[9*m_src +: 9];
      e.tout = TO_EN && (m_beats == MB) && !e.flit[8];
      if (e.tout) e.flit[8] = 1'b1;
      exp_q.push_back(e);
      if (e.flit[8]) begin
        m_busy = 1'b0;
        m_next = (m_src + 1) % 4;
      end
    end
  end

  // Monitor: every grant or beat the DUT shows consumes one expectation
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset) begin
      if (timeout_err) to_count++;
      if (data_out_valid || master_response != 4'd0) begin
        checkOutput("pending_expectation", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (data_out_valid) beat_count++;
          else grant_log.push_back(int'(grant_src));
          checkOutput("event_kind", 32'(data_out_valid), 32'(e.beat));
          checkOutput("grant_src", 32'(grant_src), 32'(e.src));
          checkOutput("grant_dst", 32'(grant_dst), 32'(e.dst));
          checkOutput("master_response", 32'(master_response), 32'(4'b0001 << e.src));
          checkOutput("data_out", 32'(data_out), e.beat ? 32'(e.flit) : 32'd0);
          checkOutput("timeout_err", 32'(timeout_err), 32'(e.tout));
        end
      end else begin
        checkOutput("missed_event", 32'(exp_q.size()), 0);
        checkOutput("idle_outputs", {grant_src, grant_dst, data_out, timeout_err}, 0);
      end
    end
  end

  task automatic startBurst(input int p, input logic [1:0] dest, input int len, input bit stream);
    for (int b = 0; b < 16; b++) begin
      flits[p][b] = {1'b0, 8'($urandom)};
      if (!stream && b == len - 1) flits[p][b][8] = 1'b1;
    end
    idx[p]    = 0;
    active[p] = 1'b1;
    drop1[p]  = 1'b0;
    which_processor[2*p +: 2] = dest;
    request_transfer[p]       = 1'b1;
    data_from_proc[9*p +: 9]  = flits[p][0];
  endtask

  // Processor agents: advance on each forwarded flit, stop after the last one
  task automatic applyStimulus();
    for (int p = 0; p < 4; p++) begin
      if (active[p] && data_out_valid && grant_src == 2'(p)) begin
        if (data_out[8]) begin
          active[p]           = 1'b0;
          request_transfer[p] = 1'b0;
          if (auto_restart) startBurst(p, 2'($urandom_range(0, 3)), 2, 1'b0);
        end else begin
          if (idx[p] < 15) idx[p]++;
          if (drop1[p]) begin
            request_transfer[p] = 1'b0;
            drop1[p]            = 1'b0;
          end
        end
      end
    end
    if (rand_mode) begin
      dst_busy = 4'($urandom);
      for (int p = 0; p < 4; p++) begin
        if (!active[p]) begin
          if ($urandom_range(0, 3) == 0) startBurst(p, 2'($urandom_range(0, 3)), $urandom_range(1, 8), 1'b0);
        end else if (idx[p] > 0) begin
          if ($urandom_range(0, 7) == 0) which_processor[2*p +: 2] = 2'($urandom);
          if ($urandom_range(0, 7) == 0) request_transfer[p] = 1'b0;
        end
      end
    end
    for (int p = 0; p < 4; p++) data_from_proc[9*p +: 9] = flits[p][idx[p]];
  endtask

  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      applyStimulus();
    end
  endtask

  task automatic drain();
    bit done;
    done     = 1'b0;
    dst_busy = 4'd0;
    for (int c = 0; c < 300 && !done; c++) begin
      runCycles(1);
      if (!active[0] && !active[1] && !active[2] && !active[3] && !data_out_valid && master_response == 4'd0)
        done = 1'b1;
    end
    checkOutput("drain_complete", 32'(done), 1);
  endtask

  task automatic clearLogs();
    grant_log.delete();
    beat_count = 0;
    to_count   = 0;
  endtask

  initial begin
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};
    checks = 0;
    errors = 0;
    reset            = 1'b0;
    request_transfer = '0;
    which_processor  = '0;
    data_from_proc   = '0;
    dst_busy         = '0;
    auto_restart     = 1'b0;
    rand_mode        = 1'b0;
    for (int p = 0; p < 4; p++) begin
      idx[p]    = 0;
      active[p] = 1'b0;
      drop1[p]  = 1'b0;
      for (int b = 0; b < 16; b++) flits[p][b] = '0;
    end
    clearLogs();

    // Power-on reset
    runCycles(2);
    checkOutput("reset_outputs", {master_response, grant_src, grant_dst, data_out, data_out_valid, timeout_err}, 0);
    reset = 1'b1;
    runCycles(1);

    // Single 3-beat burst from proc1 to dest 3
    clearLogs();
    startBurst(1, 2'd3, 3, 1'b0);
    drain();
    checkOutput("t1_grants", grant_log.size(), 1);
    checkOutput("t1_grant_src", grant_log[0], 1);
    checkOutput("t1_beats", beat_count, 3);

    // Repeat burst, reset asserted while beat 2 is on data_out
    startBurst(1, 2'd3, 3, 1'b0);
    for (int c = 0; c < 20 && idx[1] < 2; c++) runCycles(1);
    checkOutput("t2_reached_beat2", idx[1], 2);
    reset = 1'b0;
    #1;
    checkOutput("t2_midburst_reset", {master_response, grant_src, grant_dst, data_out, data_out_valid, timeout_err}, 0);
    for (int p = 0; p < 4; p++) active[p] = 1'b0;
    request_transfer = '0;
    runCycles(2);
    reset = 1'b1;
    runCycles(1);

    // Round-robin with all four sources requesting continuously
    clearLogs();
    auto_restart = 1'b1;
    for (int p = 0; p < 4; p++) startBurst(p, 2'($urandom_range(0, 3)), 2, 1'b0);
    for (int c = 0; c < 100 && grant_log.size() < 5; c++) runCycles(1);
    auto_restart = 1'b0;
    checkOutput("rr_grants_seen", 32'(grant_log.size() >= 5), 1);
    for (int i = 0; i < 5; i++) checkOutput("rr_order", grant_log[i], exp_rr[i]);
    drain();

    // Busy destination blocks proc0 until it clears
    clearLogs();
    dst_busy = 4'b0100;
    startBurst(0, 2'd2, 2, 1'b0);
    startBurst(1, 2'd1, 2, 1'b0);
    runCycles(8);
    drain();
    checkOutput("busy_grants", grant_log.size(), 2);
    checkOutput("busy_first", grant_log[0], 1);
    checkOutput("busy_second", grant_log[1], 0);

    // Request dropped after the first beat of a 5-beat burst
    clearLogs();
    startBurst(2, 2'd0, 5, 1'b0);
    drop1[2] = 1'b1;
    drain();
    checkOutput("drop_beats", beat_count, 5);
    checkOutput("drop_grant_src", grant_log[0], 2);

    // Self-send from proc3, then wrap to proc0
    clearLogs();
    startBurst(3, 2'd3, 3, 1'b0);
    runCycles(2);
    startBurst(0, 2'd1, 2, 1'b0);
    drain();
    checkOutput("wrap_grants", grant_log.size(), 2);
    checkOutput("wrap_first", grant_log[0], 3);
    checkOutput("wrap_second", grant_log[1], 0);
    checkOutput("wrap_beats", beat_count, 5);

`ifdef ARB_TIMEOUT_EN
    // Streaming source without tlast is cut off at MB beats
    clearLogs();
    startBurst(1, 2'd2, 16, 1'b1);
    drain();
    checkOutput("timeout_beats", beat_count, MB);
    checkOutput("timeout_pulses", to_count, 1);
`endif

    // Randomized traffic
    rand_mode = 1'b1;
    runCycles(3000);
    rand_mode = 1'b0;
    drain();

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_master_arbiter.md
Name: noc_master_arbiter

Overview:
- Central grant stage directly downstream of the four processing units.
- Takes each unit's registered transfer request, 2-bit destination and 9-bit flit stream {tlast, payload[7:0]}.
- Grants one source at a time, round-robin, and holds the grant until that source's tlast flit.
- Drives master_response back to the granted unit and forwards its flits, with source and destination tags, to the router fabric.

Parameters:
- N_PROC, 4, number of processing units. Fixed at 4 because destination fields are 2 bits.
- FLIT_W, 9, flit width. Bit 8 is tlast; bits 7:0 are payload.
- MAX_BURST, 255, beat limit before forced release. Used only with ARB_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. 0 = reset asserted.
- request_transfer  in  4  bit i = processor i requests the bus.
- which_processor  in  8  packed destinations; bits [2i+1:2i] belong to processor i.
- data_from_proc  in  36  packed flits; bits [9i+8:9i] belong to processor i.
- dst_busy  in  4  bit d = destination d cannot accept a new burst.
- master_response  out  4  one-hot grant level back to the processors.
- grant_src  out  2  index of the granted source.
- grant_dst  out  2  latched destination of the current burst.
- data_out  out  9  registered flit from the granted source.
- data_out_valid  out  1  data_out holds a live flit.
- timeout_err  out  1  one-cycle pulse when a burst is force-released.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0.
  - master_response=0, grant_src=0, grant_dst=0.
  - data_out=0, data_out_valid=0, timeout_err=0.
  - Reset mid-burst aborts the burst at once; no tlast is emitted.
- State machine, two states: IDLE and XFER.
- IDLE:
  - Eligible[i] = request_transfer[i] & ~dst_busy[which_processor[i]].
  - Search order is rr_ptr, rr_ptr+1, … modulo 4. The first eligible index wins.
  - On a win at edge N: latch grant_src=i and grant_dst=which_processor[i]; state moves to XFER.
  - master_response[i]=1 from cycle N+1 (registered).
  - With no eligible request, stay in IDLE with all outputs held at 0.
  - A request whose src equals its dst is legal and is handled normally.
- XFER:
  - Every cycle: data_out <= data_from_proc[grant_src] and data_out_valid <= 1.
  - If the sampled flit has bit 8 = 1:
    - that flit is forwarded as the last beat;
    - state moves to IDLE and rr_ptr = grant_src+1 (mod 4);
    - master_response and data_out_valid return to 0 on the following cycle.
  - Deasserting request_transfer, or changing which_processor, during XFER is ignored. Only tlast (or a timeout) ends the burst.
  - dst_busy is checked only at grant time; it is ignored during XFER.
- Grant spacing: at least one IDLE cycle lies between consecutive bursts, so the minimum turnaround is 1 cycle.
- Latency: request sampled at edge N → master_response at N+1 → first data_out_valid at N+2.
- Fairness: a source that has just been served has the lowest priority for the next grant.
- Widths:
  - rr_ptr is 2 bits and wraps 3→0.
  - The beat counter is 8 bits. It saturates and never wraps silently.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit beat counter clears on grant and increments on each XFER beat.
  - When it reaches MAX_BURST without tlast, the current flit is forwarded with bit 8 forced to 1.
  - timeout_err pulses for 1 cycle, the burst is released exactly as on tlast, and rr_ptr advances.
- When not defined:
  - No counter is built and bursts are unbounded.
  - timeout_err is tied to 0.

Test Plan:
- Reset mid-burst:
  - Stimulus: reset=0, then release; request_transfer=4'b0010 with dest 3, idle cycles, then a flit with tlast on the 3rd beat. Pull reset=0 during beat 2 of a repeat burst.
  - Required: master_response=4'b0010 one cycle after the request; grant_dst=3; exactly 3 valid beats, the last with data_out[8]=1.
  - Required on mid-burst reset: all outputs 0 immediately.
- Round-robin fairness:
  - Stimulus: request_transfer=4'b1111 held, each burst 2 beats.
  - Required: grant order 0,1,2,3,0; one IDLE gap between bursts.
- Destination busy:
  - Stimulus: requests 4'b0011, proc0 dest=2, proc1 dest=1, dst_busy=4'b0100.
  - Required: proc1 is granted first. proc0 is granted after dst_busy clears.
- Request drop mid-burst:
  - Stimulus: proc2 drops request_transfer on beat 1 of a 5-beat burst.
  - Required: the grant is held; all 5 beats are forwarded, ending on tlast.
- Self-send and wrap:
  - Stimulus: proc3 requests dest 3, then proc0 requests.
  - Required: proc3's burst completes normally; rr_ptr wraps to 0 and proc0 is granted next.
- Timeout (ARB_TIMEOUT_EN, MAX_BURST=4):
  - Stimulus: proc1 streams with no tlast.
  - Required: beat 4 has data_out[8]=1; timeout_err pulses for 1 cycle; master_response drops the next cycle.
